// File: rtl/spi_slave_param.sv
// SPI slave, all four CPOL/CPHA modes, oversampled in the P_CLK domain.
// Ports: P_CLK/reset, SPI pins (S_CLK, i_SS, i_MOSI, o_MISO, o_MISO_OE),
//        TX side (i_TX_DATA, i_TX_DV, o_TX_READY, o_TX_DONE, o_TX_UNDERRUN),
//        RX side (o_RX_DV, o_RX_DATA).
module spi_slave_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 1,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_DATA = '0
) (
    input  logic                  P_CLK,
    input  logic                  reset,
    input  logic                  S_CLK,
    input  logic                  i_SS,
    input  logic                  i_MOSI,
    output logic                  o_MISO,
    output logic                  o_MISO_OE,
    input  logic [DATA_WIDTH-1:0] i_TX_DATA,
    input  logic                  i_TX_DV,
    output logic                  o_TX_READY,
    output logic                  o_TX_DONE,
    output logic                  o_TX_UNDERRUN,
    output logic                  o_RX_DV,
    output logic [DATA_WIDTH-1:0] o_RX_DATA
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic L_CPOL = (CPOL != 0);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES:0]   r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_ss_prev;

    logic [0:0]            r_state;
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_valid;

    logic                  w_sclk, w_ss, w_mosi;
    logic                  w_edge, w_lead, w_trail;
    logic                  w_sample, w_shift;
    logic                  w_ss_fall, w_ss_rise;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_tx_src;
    logic [DATA_WIDTH-1:0] w_tx_next;
    logic                  w_tx_bit;
    logic [DATA_WIDTH-1:0] w_rx_next;

    // MOSI gets one extra stage so it lines up with the S_CLK edge detect
    always_ff @(posedge P_CLK or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= {SYNC_STAGES{L_CPOL}};
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= L_CPOL;
            r_ss_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], S_CLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_SS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-1:0], i_MOSI};
            r_sclk_prev <= w_sclk;
            r_ss_prev   <= w_ss;
        end
    end

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES];
    assign w_edge    = w_sclk ^ r_sclk_prev;
    assign w_lead    = w_edge && (w_sclk != L_CPOL);
    assign w_trail   = w_edge && (w_sclk == L_CPOL);
    assign w_sample  = (CPHA == 0) ? w_lead : w_trail;
    assign w_shift   = (CPHA == 0) ? w_trail : w_lead;
    assign w_ss_fall = r_ss_prev && !w_ss;
    assign w_ss_rise = !r_ss_prev && w_ss;

    // A shift edge with the counter at 0 opens a word: for CPHA=0 that is
    // the edge after a completed word, for CPHA=1 the first edge of a word.
    assign w_load = ((r_state == ST_IDLE) && w_ss_fall && (CPHA == 0))
                 || ((r_state == ST_ACTIVE) && !w_ss_rise && w_shift
                     && (r_bit_cnt == '0));

    assign w_load_data = r_hold_valid ? r_hold : IDLE_DATA;
    assign w_tx_src    = w_load ? w_load_data : r_tx_shift;
    assign w_tx_bit    = (MSB_FIRST != 0) ? w_tx_src[DATA_WIDTH-1]
                                          : w_tx_src[0];
    assign w_tx_next   = (MSB_FIRST != 0)
                       ? {w_tx_src[DATA_WIDTH-2:0], 1'b0}
                       : {1'b0, w_tx_src[DATA_WIDTH-1:1]};
    assign w_rx_next   = (MSB_FIRST != 0)
                       ? {r_rx_shift[DATA_WIDTH-2:0], w_mosi}
                       : {w_mosi, r_rx_shift[DATA_WIDTH-1:1]};

    // A write coinciding with a load is not bypassed; it survives the clear
    always_ff @(posedge P_CLK or posedge reset) begin
        if (reset) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            if (w_load)
                r_hold_valid <= 1'b0;
            if (i_TX_DV && !r_hold_valid) begin
                r_hold       <= i_TX_DATA;
                r_hold_valid <= 1'b1;
            end
        end
    end

    assign o_TX_READY = !r_hold_valid;
    assign o_MISO_OE  = (r_state == ST_ACTIVE);

    always_ff @(posedge P_CLK or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            o_MISO        <= 1'b0;
            o_RX_DATA     <= '0;
            o_RX_DV       <= 1'b0;
            o_TX_DONE     <= 1'b0;
            o_TX_UNDERRUN <= 1'b0;
        end else begin
            o_RX_DV       <= 1'b0;
            o_TX_DONE     <= 1'b0;
            o_TX_UNDERRUN <= w_load && !r_hold_valid;
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt  <= '0;
                    r_rx_shift <= '0;
                    o_MISO     <= 1'b0;
                    if (w_ss_fall) begin
                        r_state <= ST_ACTIVE;
                        if (w_load) begin
                            o_MISO     <= w_tx_bit;
                            r_tx_shift <= w_tx_next;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_ss_rise) begin
                        // abort: partial word is dropped silently
                        r_state    <= ST_IDLE;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                        o_MISO     <= 1'b0;
                    end else begin
                        if (w_shift) begin
                            o_MISO     <= w_tx_bit;
                            r_tx_shift <= w_tx_next;
                        end
                        if (w_sample) begin
                            r_rx_shift <= w_rx_next;
                            if (r_bit_cnt == LAST) begin
                                r_bit_cnt <= '0;
                                o_RX_DATA <= w_rx_next;
                                o_RX_DV   <= 1'b1;
                                o_TX_DONE <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CW'(1);
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: three instances (mode 2 W8 MSB, mode 3 W8 MSB,
// mode 1 W16 LSB) driven by a behavioural SPI master and holding-reg model.
module tb_spi_slave_param;

    localparam int H = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0] sclk, ss, mosi, dv;
    logic [2:0] miso, oe, rdy, done, und, rxdv;
    logic [2:0][15:0] txd;
    logic [7:0]  rx0, rx1;
    logic [15:0] rx2;

    spi_slave_param #(.DATA_WIDTH(8), .CPOL(1), .CPHA(0), .MSB_FIRST(1)) u_m2 (
        .P_CLK(clk), .reset(rst), .S_CLK(sclk[0]), .i_SS(ss[0]),
        .i_MOSI(mosi[0]), .o_MISO(miso[0]), .o_MISO_OE(oe[0]),
        .i_TX_DATA(txd[0][7:0]), .i_TX_DV(dv[0]), .o_TX_READY(rdy[0]),
        .o_TX_DONE(done[0]), .o_TX_UNDERRUN(und[0]), .o_RX_DV(rxdv[0]),
        .o_RX_DATA(rx0));

    spi_slave_param #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u_m3 (
        .P_CLK(clk), .reset(rst), .S_CLK(sclk[1]), .i_SS(ss[1]),
        .i_MOSI(mosi[1]), .o_MISO(miso[1]), .o_MISO_OE(oe[1]),
        .i_TX_DATA(txd[1][7:0]), .i_TX_DV(dv[1]), .o_TX_READY(rdy[1]),
        .o_TX_DONE(done[1]), .o_TX_UNDERRUN(und[1]), .o_RX_DV(rxdv[1]),
        .o_RX_DATA(rx1));

    spi_slave_param #(.DATA_WIDTH(16), .CPOL(0), .CPHA(1), .MSB_FIRST(0)) u_m1 (
        .P_CLK(clk), .reset(rst), .S_CLK(sclk[2]), .i_SS(ss[2]),
        .i_MOSI(mosi[2]), .o_MISO(miso[2]), .o_MISO_OE(oe[2]),
        .i_TX_DATA(txd[2]), .i_TX_DV(dv[2]), .o_TX_READY(rdy[2]),
        .o_TX_DONE(done[2]), .o_TX_UNDERRUN(und[2]), .o_RX_DV(rxdv[2]),
        .o_RX_DATA(rx2));

    int n_chk = 0;
    int n_fail = 0;
    int cur = 0;
    int n_rx, n_done, n_und, e_und;
    logic [15:0] rxq[$];

    bit          hv[3];
    logic [15:0] hd[3];

    logic [15:0] fmw[4];
    bit          fwr[4];
    logic [15:0] fwv[4];

    function automatic int wid(int d);
        return (d == 2) ? 16 : 8;
    endfunction
    function automatic logic cpol(int d);
        return (d == 2) ? 1'b0 : 1'b1;
    endfunction
    function automatic bit cpha(int d);
        return d != 0;
    endfunction
    function automatic bit msbf(int d);
        return d != 2;
    endfunction
    function automatic logic [15:0] rxval(int d);
        case (d)
            0: return {8'h00, rx0};
            1: return {8'h00, rx1};
            default: return rx2;
        endcase
    endfunction
    function automatic logic tbit(int d, logic [15:0] w, int i);
        return msbf(d) ? w[wid(d)-1-i] : w[i];
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_load(int d, output logic [15:0] v);
        if (hv[d]) begin
            v = hd[d];
            hv[d] = 1'b0;
        end else begin
            v = 16'h0000;
            e_und++;
        end
    endtask

    task automatic dut_write(int d, logic [15:0] v);
        txd[d] = v;
        dv[d] = 1'b1;
        @(negedge clk);
        dv[d] = 1'b0;
        if (!hv[d]) begin
            hv[d] = 1'b1;
            hd[d] = v;
        end
    endtask

    always @(negedge clk) begin
        if (rxdv[cur]) begin
            n_rx++;
            rxq.push_back(rxval(cur));
        end
        if (done[cur]) n_done++;
        if (und[cur]) n_und++;
    end

    task automatic clr(int d);
        cur = d;
        n_rx = 0;
        n_done = 0;
        n_und = 0;
        e_und = 0;
        rxq.delete();
    endtask

    task automatic run_frame(int d, int nw, string tag);
        int W;
        logic p, b;
        logic [15:0] ld[5];
        logic [15:0] got;
        W = wid(d);
        p = cpol(d);
        b = 1'b0;
        clr(d);
        ss[d] = 1'b0;
        if (!cpha(d)) begin
            m_load(d, ld[0]);
            mosi[d] = tbit(d, fmw[0], 0);
        end
        waitc(H);
        chk($sformatf("%s/oe", tag), oe[d], 1);
        for (int w = 0; w < nw; w++) begin
            if (cpha(d)) m_load(d, ld[w]);
            got = '0;
            for (int i = 0; i < W; i++) begin
                if (!cpha(d)) b = miso[d];
                sclk[d] = ~p;
                if (cpha(d)) mosi[d] = tbit(d, fmw[w], i);
                if (i == 3 && fwr[w]) begin
                    dut_write(d, fwv[w]);
                    waitc(H - 1);
                end else begin
                    waitc(H);
                end
                if (cpha(d)) b = miso[d];
                sclk[d] = p;
                if (!cpha(d)) begin
                    if (i < W - 1) mosi[d] = tbit(d, fmw[w], i + 1);
                    else if (w < nw - 1) mosi[d] = tbit(d, fmw[w+1], 0);
                end
                got[msbf(d) ? W-1-i : i] = b;
                waitc(H);
            end
            if (!cpha(d)) m_load(d, ld[w+1]);
            chk($sformatf("%s/miso_w%0d", tag, w), got, ld[w]);
        end
        ss[d] = 1'b1;
        waitc(2 * H);
        chk($sformatf("%s/oe_idle", tag), oe[d], 0);
        chk($sformatf("%s/miso_idle", tag), miso[d], 0);
        chk($sformatf("%s/rx_dv_cnt", tag), n_rx, nw);
        chk($sformatf("%s/done_cnt", tag), n_done, nw);
        chk($sformatf("%s/und_cnt", tag), n_und, e_und);
        chk($sformatf("%s/ready", tag), rdy[d], !hv[d]);
        for (int w = 0; w < nw; w++)
            if (w < rxq.size())
                chk($sformatf("%s/rx_w%0d", tag, w), rxq[w], fmw[w]);
    endtask

    task automatic run_abort(int d, int nb, string tag);
        logic p;
        logic [15:0] tmp;
        p = cpol(d);
        clr(d);
        ss[d] = 1'b0;
        if (!cpha(d)) m_load(d, tmp);
        waitc(H);
        for (int i = 0; i < nb; i++) begin
            if (cpha(d) && i == 0) m_load(d, tmp);
            sclk[d] = ~p;
            mosi[d] = 1'($urandom);
            waitc(H);
            sclk[d] = p;
            waitc(H);
        end
        ss[d] = 1'b1;
        waitc(2 * H);
        chk($sformatf("%s/rx_dv_cnt", tag), n_rx, 0);
        chk($sformatf("%s/done_cnt", tag), n_done, 0);
        chk($sformatf("%s/und_cnt", tag), n_und, e_und);
        chk($sformatf("%s/oe_idle", tag), oe[d], 0);
        chk($sformatf("%s/ready", tag), rdy[d], !hv[d]);
    endtask

    task automatic no_writes();
        for (int w = 0; w < 4; w++) begin
            fwr[w] = 1'b0;
            fwv[w] = '0;
        end
    endtask

    initial begin
        int d, nw;
        logic [15:0] mask;
        rst = 1'b1;
        ss = 3'b111;
        sclk = 3'b011;
        mosi = '0;
        dv = '0;
        txd = '0;
        for (int k = 0; k < 3; k++) begin
            hv[k] = 1'b0;
            hd[k] = '0;
        end
        no_writes();
        waitc(4);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("init%0d/outs", k),
                {miso[k], oe[k], rdy[k], done[k], und[k], rxdv[k]}, 6'b001000);
            chk($sformatf("init%0d/rx", k), rxval(k), 0);
        end
        rst = 1'b0;
        waitc(5);

        dut_write(1, 16'h00A5);
        chk("m3/ready_full", rdy[1], 0);
        fmw[0] = 16'h003C;
        run_frame(1, 1, "m3");

        dut_write(1, 16'h0011);
        fmw[0] = 16'h005E;
        fmw[1] = 16'h00C7;
        fwr[0] = 1'b1;
        fwv[0] = 16'h0022;
        run_frame(1, 2, "two");
        chk("two/no_und", n_und, 0);
        no_writes();

        fmw[0] = 16'h00FF;
        run_frame(1, 1, "und");
        chk("und/pulse", n_und, 1);

        run_abort(1, 5, "abt");
        fmw[0] = 16'h005A;
        run_frame(1, 1, "abt2");
        chk("abt2/rx_data", rx1, 8'h5A);

        dut_write(2, 16'hBEEF);
        fmw[0] = 16'h1234;
        run_frame(2, 1, "w16");
        chk("w16/rx_data", rx2, 16'h1234);

        dut_write(0, 16'h0069);
        fmw[0] = 16'h0081;
        fmw[1] = 16'h0042;
        fwr[0] = 1'b1;
        fwv[0] = 16'h00D3;
        run_frame(0, 2, "m2");
        no_writes();
        run_abort(0, 5, "abt_m2");

        // reset in the middle of a word with holding full
        clr(1);
        ss[1] = 1'b0;
        waitc(H);
        for (int i = 0; i < 3; i++) begin
            sclk[1] = 1'b0;
            waitc(H);
            sclk[1] = 1'b1;
            waitc(H);
        end
        sclk[1] = 1'b0;
        dut_write(1, 16'h0099);
        waitc(2);
        chk("rst/pre_ready", rdy[1], 0);
        chk("rst/pre_oe", oe[1], 1);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d/outs", k),
                {miso[k], oe[k], rdy[k], done[k], und[k], rxdv[k]}, 6'b001000);
            chk($sformatf("rst%0d/rx", k), rxval(k), 0);
            hv[k] = 1'b0;
        end
        ss[1] = 1'b1;
        sclk[1] = 1'b1;
        waitc(4);
        rst = 1'b0;
        waitc(4);
        dut_write(1, 16'h003C);
        fmw[0] = 16'h00C3;
        run_frame(1, 1, "post_rst");

        for (int it = 0; it < 30; it++) begin
            d = int'($urandom % 3);
            nw = 1 + int'($urandom % 3);
            mask = (wid(d) == 8) ? 16'h00FF : 16'hFFFF;
            for (int w = 0; w < 4; w++) begin
                fmw[w] = 16'($urandom) & mask;
                fwr[w] = 1'($urandom);
                fwv[w] = 16'($urandom) & mask;
            end
            chk($sformatf("rnd%0d/pre_ready", it), rdy[d], !hv[d]);
            if ($urandom % 2 == 0) dut_write(d, 16'($urandom) & mask);
            if (hv[d] && ($urandom % 2 == 0))
                dut_write(d, 16'($urandom) & mask);
            run_frame(d, nw, $sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
